// File: rtl/plic_mc.sv
// plic_mc: multi-context platform interrupt controller.
// NSRC edge-triggered gateways feed NCTX hart contexts. Each context has its own
// enable mask, threshold and claim/complete register, and drives one external_irq bit.
// Optional feature macro: PLIC_TRIGGER_CFG_EN adds a per-source level/edge trigger
// register at offset 0x001080. When it is undefined, every source is edge triggered.
`timescale 1ns/1ps
module plic_mc #(
  parameter logic [31:0] BASE   = 32'h0C000000,
  parameter int          NSRC   = 31,
  parameter int          NCTX   = 2,
  parameter int          PRIO_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            read_en,
  output logic [31:0]     rdata,
  output logic            addr_valid,
  input  logic [31:0]     irq_sources,
  output logic [NCTX-1:0] external_irq
);

  // Bits 1..NSRC; bit 0 and bits above NSRC never hold state.
  localparam logic [63:0] MASK64   = ((64'd1 << (NSRC + 1)) - 64'd1) & ~64'd1;
  localparam logic [31:0] SRC_MASK = MASK64[31:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  logic [PRIO_W-1:0] prio_q [1:NSRC];
  logic [31:0]       pend_q, claimed_q, prev_q, trig_q;
  logic [31:0]       en_q  [NCTX];
  logic [PRIO_W-1:0] thr_q [NCTX];

  logic [31:0]       off;
  logic              sel_prio, sel_pend, sel_trig, sel_en, sel_thr, sel_claim;
  logic [4:0]        src_idx;
  logic [1:0]        ctx_idx;

  logic [4:0]        best [NCTX];
  logic [PRIO_W-1:0] bp;

  logic              wr, claim_fire;
  logic [4:0]        claim_id;
  logic [31:0]       wnew, cid, claim_mask, cpl_mask;
  logic [31:0]       rise, pend_edge, pend_lvl, pend_d, claimed_d;

`ifndef PLIC_TRIGGER_CFG_EN
  assign trig_q = 32'h0;
`endif

  // Address decode: which register the bus address selects, and for which source/context.
  always_comb begin
    off       = addr - BASE;
    sel_prio  = 1'b0;
    sel_pend  = 1'b0;
    sel_trig  = 1'b0;
    sel_en    = 1'b0;
    sel_thr   = 1'b0;
    sel_claim = 1'b0;
    src_idx   = off[6:2];
    ctx_idx   = 2'd0;
    if (addr >= BASE && addr[1:0] == 2'b00) begin
      if (off < 32'(4 * (NSRC + 1))) sel_prio = 1'b1;
      else if (off == 32'h0000_1000) sel_pend = 1'b1;
`ifdef PLIC_TRIGGER_CFG_EN
      else if (off == 32'h0000_1080) sel_trig = 1'b1;
`endif
      else if (off >= 32'h0000_2000 && off < 32'h0000_2000 + 32'(NCTX * 128)
               && off[6:0] == 7'd0) begin
        sel_en  = 1'b1;
        ctx_idx = off[8:7];
      end
      else if (off >= 32'h0020_0000 && off < 32'h0020_0000 + 32'(NCTX * 4096)) begin
        ctx_idx = off[13:12];
        if (off[11:0] == 12'h000)      sel_thr   = 1'b1;
        else if (off[11:0] == 12'h004) sel_claim = 1'b1;
      end
    end
  end

  // Per-context arbitration: highest priority above threshold, ties to the lowest ID.
  always_comb begin
    bp = '0;
    for (int c = 0; c < NCTX; c++) begin
      bp      = thr_q[c];
      best[c] = 5'd0;
      for (int i = 1; i <= NSRC; i++) begin
        if (pend_q[i] && en_q[c][i] && !claimed_q[i] && prio_q[i] > bp) begin
          bp      = prio_q[i];
          best[c] = 5'(i);
        end
      end
      external_irq[c] = (best[c] != 5'd0);
    end
  end

  // Read mux plus the claim and complete side-effect requests.
  always_comb begin
    rdata      = 32'h0;
    addr_valid = sel_prio | sel_pend | sel_trig | sel_en | sel_thr | sel_claim;
    wr         = |wstrb;
    cid        = merge_bytes(32'h0, wdata, wstrb);
    claim_fire = 1'b0;
    claim_id   = 5'd0;
    cpl_mask   = 32'h0;
    if (sel_prio)
      for (int i = 1; i <= NSRC; i++)
        if (src_idx == 5'(i)) rdata = 32'(prio_q[i]);
    if (sel_pend) rdata = pend_q;
    if (sel_trig) rdata = trig_q;
    for (int c = 0; c < NCTX; c++) begin
      if (ctx_idx == 2'(c)) begin
        if (sel_en)  rdata = en_q[c];
        if (sel_thr) rdata = 32'(thr_q[c]);
        if (sel_claim) begin
          rdata = 32'(best[c]);
          if (read_en && best[c] != 5'd0) begin
            claim_fire = 1'b1;
            claim_id   = best[c];
          end
          if (wr && cid >= 32'd1 && cid <= 32'(NSRC) && en_q[c][cid[4:0]])
            cpl_mask = 32'd1 << cid[4:0];
        end
      end
    end
    // For plain R/W registers rdata is the current value, so this is a byte-lane merge.
    wnew = merge_bytes(rdata, wdata, wstrb);
  end

  // Gateway and claim bookkeeping; a new edge beats a simultaneous claim clear.
  always_comb begin
    claim_mask = claim_fire ? (32'd1 << claim_id) : 32'h0;
    rise       = irq_sources & ~prev_q & SRC_MASK;
    pend_edge  = (pend_q & ~claim_mask) | rise;
    pend_lvl   = irq_sources & SRC_MASK & ~claimed_q & ~claim_mask;
    pend_d     = (trig_q & pend_lvl) | (~trig_q & pend_edge);
    claimed_d  = (claimed_q & ~cpl_mask) | claim_mask;
  end

  // State registers and bus writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= 32'h0;
      claimed_q <= 32'h0;
      prev_q    <= 32'h0;
      for (int i = 1; i <= NSRC; i++) prio_q[i] <= '0;
      for (int c = 0; c < NCTX; c++) begin
        en_q[c]  <= 32'h0;
        thr_q[c] <= '0;
      end
`ifdef PLIC_TRIGGER_CFG_EN
      trig_q    <= 32'h0;
`endif
    end else begin
      prev_q    <= irq_sources & SRC_MASK;
      pend_q    <= pend_d;
      claimed_q <= claimed_d;
      if (wr) begin
        if (sel_prio)
          for (int i = 1; i <= NSRC; i++)
            if (src_idx == 5'(i)) prio_q[i] <= wnew[PRIO_W-1:0];
        for (int c = 0; c < NCTX; c++) begin
          if (ctx_idx == 2'(c)) begin
            if (sel_en)  en_q[c]  <= wnew & SRC_MASK;
            if (sel_thr) thr_q[c] <= wnew[PRIO_W-1:0];
          end
        end
`ifdef PLIC_TRIGGER_CFG_EN
        if (sel_trig) trig_q <= wnew & SRC_MASK;
`endif
      end
    end
  end

endmodule

// File: tb/tb_plic_mc.sv
// tb_plic_mc: directed bench for plic_mc with a behavioural reference model.
// Build with PLIC_TRIGGER_CFG_EN defined to exercise the level-trigger register.
`timescale 1ns/1ps
module tb_plic_mc;
  localparam logic [31:0] BASE = 32'h0C000000;
  localparam int NSRC = 31;
  localparam int NCTX = 2;
  localparam int PW   = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     addr = 32'h0, wdata = 32'h0, irq_sources = 32'h0;
  logic [3:0]      wstrb = 4'h0;
  logic            read_en = 1'b0;
  logic [31:0]     rdata;
  logic            addr_valid;
  logic [NCTX-1:0] external_irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  plic_mc #(.BASE(BASE), .NSRC(NSRC), .NCTX(NCTX), .PRIO_W(PW)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .read_en(read_en), .rdata(rdata), .addr_valid(addr_valid),
    .irq_sources(irq_sources), .external_irq(external_irq)
  );

  function automatic logic [31:0] a_prio(int i); return BASE + 32'(4 * i); endfunction
  function automatic logic [31:0] a_en(int c);   return BASE + 32'h2000 + 32'(c * 128); endfunction
  function automatic logic [31:0] a_thr(int c);  return BASE + 32'h200000 + 32'(c * 4096); endfunction
  function automatic logic [31:0] a_clm(int c);  return BASE + 32'h200004 + 32'(c * 4096); endfunction
  localparam logic [31:0] A_PEND = BASE + 32'h1000;
  localparam logic [31:0] A_TRIG = BASE + 32'h1080;

  // Reference model state, kept as plain per-source arrays.
  int         m_prio [32];
  bit         m_pend [32];
  bit         m_claimed [32];
  bit         m_prev [32];
  bit  [31:0] m_en [NCTX];
  int         m_thr [NCTX];
  bit  [31:0] m_trig;

  // Scan priority levels from the top down; the first eligible ID at a level wins.
  function automatic int m_best(int c);
    for (int p = (1 << PW) - 1; p > m_thr[c]; p--)
      for (int i = 1; i <= NSRC; i++)
        if (m_pend[i] && m_en[c][i] && !m_claimed[i] && m_prio[i] == p) return i;
    return 0;
  endfunction

  task automatic m_read(input logic [31:0] a, output logic v, output logic [31:0] d);
    v = 1'b1;
    d = 32'h0;
    for (int i = 0; i <= NSRC; i++)
      if (a == a_prio(i)) begin d = (i == 0) ? 32'h0 : 32'(m_prio[i]); return; end
    if (a == A_PEND) begin
      for (int i = 1; i <= NSRC; i++) d[i] = m_pend[i];
      return;
    end
`ifdef PLIC_TRIGGER_CFG_EN
    if (a == A_TRIG) begin d = m_trig; return; end
`endif
    for (int c = 0; c < NCTX; c++) begin
      if (a == a_en(c))  begin d = m_en[c]; return; end
      if (a == a_thr(c)) begin d = 32'(m_thr[c]); return; end
      if (a == a_clm(c)) begin d = 32'(m_best(c)); return; end
    end
    v = 1'b0;
  endtask

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur, nv;
    logic        v;
    m_read(a, v, cur);
    nv = cur;
    for (int b = 0; b < 4; b++) if (s[b]) nv[8*b +: 8] = d[8*b +: 8];
    for (int i = 1; i <= NSRC; i++) if (a == a_prio(i)) m_prio[i] = int'(nv[2:0]);
`ifdef PLIC_TRIGGER_CFG_EN
    if (a == A_TRIG) m_trig = nv & 32'hFFFF_FFFE;
`endif
    for (int c = 0; c < NCTX; c++) begin
      if (a == a_en(c))  m_en[c]  = nv & 32'hFFFF_FFFE;
      if (a == a_thr(c)) m_thr[c] = int'(nv[2:0]);
    end
  endtask

  // Model advances on every rising clock edge from the inputs the bench is driving.
  always @(posedge clk) begin : model_step
    int          cl, cp;
    logic [31:0] id;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_prio[i] = 0; m_pend[i] = 0; m_claimed[i] = 0; m_prev[i] = 0;
      end
      for (int c = 0; c < NCTX; c++) begin m_en[c] = 0; m_thr[c] = 0; end
      m_trig = 0;
    end else begin
      cl = 0;
      cp = 0;
      for (int c = 0; c < NCTX; c++) begin
        if (read_en && addr == a_clm(c)) cl = m_best(c);
        if (wstrb != 4'h0 && addr == a_clm(c)) begin
          id = 32'h0;
          for (int b = 0; b < 4; b++) if (wstrb[b]) id[8*b +: 8] = wdata[8*b +: 8];
          if (id >= 1 && id <= NSRC && m_en[c][id[4:0]]) cp = int'(id);
        end
      end
      for (int i = 1; i <= NSRC; i++) begin
        if (m_trig[i]) m_pend[i] = irq_sources[i] && !m_claimed[i] && i != cl;
        else           m_pend[i] = (irq_sources[i] && !m_prev[i]) || (m_pend[i] && i != cl);
        m_claimed[i] = (i == cl) || (m_claimed[i] && i != cp);
        m_prev[i]    = irq_sources[i];
      end
      if (wstrb != 4'h0) m_write(addr, wdata, wstrb);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: external_irq against the model.
  always @(posedge clk) begin
    logic [31:0] e;
    #1;
    e = 32'h0;
    for (int c = 0; c < NCTX; c++) e[c] = (m_best(c) != 0);
    chk("irq_model", 32'(external_irq), e);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    addr = a; wdata = d; wstrb = s;
    @(negedge clk);
    wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, input string nm,
                          output logic [31:0] d, output logic v);
    logic [31:0] ed;
    logic        ev;
    @(negedge clk);
    addr = a; read_en = 1'b1;
    #1;
    m_read(a, ev, ed);
    d = rdata;
    v = addr_valid;
    chk({nm, "_rdata"}, rdata, ed);
    chk({nm, "_valid"}, 32'(addr_valid), 32'(ev));
    @(negedge clk);
    read_en = 1'b0; addr = 32'h0;
  endtask

  initial begin
    logic [31:0] d;
    logic        v;
    int          exp3 [3];
    exp3 = '{3, 4, 2};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    bus_read(A_PEND, "rst_pend", d, v);   chk("rst_pend_lit", d, 32'h0);
    bus_read(a_en(0), "rst_en0", d, v);   chk("rst_en0_lit", d, 32'h0);
    bus_read(a_en(1), "rst_en1", d, v);   chk("rst_en1_lit", d, 32'h0);
    chk("rst_irq_lit", 32'(external_irq), 32'h0);
    bus_read(32'h0D000000, "unmapped", d, v);
    chk("unmapped_rdata_lit", d, 32'h0);
    chk("unmapped_valid_lit", 32'(v), 32'h0);

    // Single source, claim and complete
    bus_write(a_prio(1), 32'd5, 4'hF);
    bus_write(a_en(0), 32'h2, 4'hF);
    @(negedge clk) irq_sources = 32'h2;
    @(negedge clk);
    chk("t1_irq_lit", 32'(external_irq), 32'h1);
    bus_read(a_clm(0), "t1_claim", d, v);  chk("t1_claim_lit", d, 32'd1);
    bus_read(A_PEND, "t1_pend", d, v);     chk("t1_pend_lit", d, 32'h0);
    chk("t1_irq_off_lit", 32'(external_irq), 32'h0);
    bus_write(a_clm(0), 32'd1, 4'hF);
    @(negedge clk) irq_sources = 32'h0;

    // Priority ordering with ties to the lowest ID
    bus_write(a_prio(2), 32'd3, 4'hF);
    bus_write(a_prio(3), 32'd7, 4'hF);
    bus_write(a_prio(4), 32'd7, 4'hF);
    bus_write(a_en(0), 32'h1C, 4'hF);
    @(negedge clk) irq_sources = 32'h1C;
    @(negedge clk);
    chk("t2_irq_lit", 32'(external_irq), 32'h1);
    for (int k = 0; k < 3; k++) begin
      bus_read(a_clm(0), "t2_claim", d, v);
      chk("t2_claim_lit", d, 32'(exp3[k]));
      bus_write(a_clm(0), 32'(exp3[k]), 4'hF);
    end
    chk("t2_irq_done_lit", 32'(external_irq), 32'h0);
    @(negedge clk) irq_sources = 32'h0;

    // Threshold boundary, cross-context claim, ignored complete
    bus_write(a_en(0), 32'h2, 4'hF);
    bus_write(a_en(1), 32'h2, 4'hF);
    bus_write(a_thr(1), 32'd5, 4'hF);
    @(negedge clk) irq_sources = 32'h2;
    @(negedge clk);
    chk("t3_irq_lit", 32'(external_irq), 32'h1);
    bus_read(a_clm(0), "t3_claim", d, v);  chk("t3_claim_lit", d, 32'd1);
    chk("t3_irq1_lit", 32'(external_irq), 32'h0);
    bus_write(a_en(1), 32'h0, 4'hF);
    bus_write(a_clm(1), 32'd1, 4'hF);
    @(negedge clk) irq_sources = 32'h0;
    @(negedge clk) irq_sources = 32'h2;
    @(negedge clk);
    chk("t3_still_claimed_lit", 32'(external_irq), 32'h0);
    bus_read(A_PEND, "t3_repend", d, v);   chk("t3_repend_lit", d, 32'h2);
    bus_write(a_clm(0), 32'd1, 4'hF);
    chk("t3_reassert_lit", 32'(external_irq), 32'h1);

    // Edge coinciding with the claim read: set wins
    @(negedge clk) irq_sources = 32'h0;
    @(negedge clk);
    addr = a_clm(0); read_en = 1'b1; irq_sources = 32'h2;
    #1;
    chk("t4_claim_lit", rdata, 32'd1);
    @(negedge clk);
    read_en = 1'b0; addr = 32'h0;
    bus_read(A_PEND, "t4_pend", d, v);     chk("t4_pend_lit", d, 32'h2);
    chk("t4_irq_lit", 32'(external_irq), 32'h0);
    bus_write(a_clm(0), 32'd1, 4'hF);
    chk("t4_irq_after_cpl_lit", 32'(external_irq), 32'h1);
    bus_read(a_clm(0), "t4_claim2", d, v); chk("t4_claim2_lit", d, 32'd1);
    bus_write(a_clm(0), 32'd1, 4'hF);
    chk("t4_irq_idle_lit", 32'(external_irq), 32'h0);
    @(negedge clk) irq_sources = 32'h0;

    // Byte lanes, register widths, read-only pending, decode edges
    bus_write(a_en(1), 32'hFFFF_FF1C, 4'b0001);
    bus_read(a_en(1), "strb_en1", d, v);   chk("strb_en1_lit", d, 32'h1C);
    bus_write(a_prio(5), 32'hFF, 4'hF);
    bus_read(a_prio(5), "prio5", d, v);    chk("prio5_lit", d, 32'd7);
    bus_write(A_PEND, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_PEND, "pend_ro", d, v);     chk("pend_ro_lit", d, 32'h0);
    bus_read(a_prio(0), "prio0", d, v);
    chk("prio0_lit", d, 32'h0);
    chk("prio0_valid_lit", 32'(v), 32'h1);
    bus_read(a_en(2), "en2", d, v);        chk("en2_valid_lit", 32'(v), 32'h0);

`ifdef PLIC_TRIGGER_CFG_EN
    // Level-triggered source re-pends after complete while the line stays high
    bus_write(A_TRIG, 32'h2, 4'hF);
    @(negedge clk) irq_sources = 32'h2;
    @(negedge clk);
    chk("lvl_irq_lit", 32'(external_irq), 32'h1);
    bus_read(a_clm(0), "lvl_claim", d, v); chk("lvl_claim_lit", d, 32'd1);
    bus_write(a_clm(0), 32'd1, 4'hF);
    bus_read(A_PEND, "lvl_repend", d, v);  chk("lvl_repend_lit", d, 32'h2);
    @(negedge clk) irq_sources = 32'h0;
    bus_read(A_PEND, "lvl_drop", d, v);    chk("lvl_drop_lit", d, 32'h0);
`else
    bus_read(A_TRIG, "trig_unmapped", d, v);
    chk("trig_unmapped_lit", 32'(v), 32'h0);
`endif

    // Source held high through a mid-operation reset pends right after
    @(negedge clk);
    irq_sources = 32'h2;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus_read(A_PEND, "post_rst_pend", d, v); chk("post_rst_pend_lit", d, 32'h2);
    chk("post_rst_irq_lit", 32'(external_irq), 32'h0);
    @(negedge clk) irq_sources = 32'h0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
